// File: rtl/sift_match_pkg.sv
// -----------------------------------------------------------------------------
// sift_match_pkg
// Shared constants and types for the descriptor streaming path.
//   CHUNK_W   : bits per emitted descriptor chunk
//   N_CHUNKS  : chunks per descriptor
//   DES_W     : full descriptor width
//   IDX_W     : width of the chunk sequence index output
//   tx_state_e: streaming FSM states
// -----------------------------------------------------------------------------
package sift_match_pkg;

    localparam int CHUNK_W  = 40;
    localparam int N_CHUNKS = 32;
    localparam int DES_W    = CHUNK_W * N_CHUNKS;
    localparam int IDX_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TAIL = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // The block reports busy only while chunks of a descriptor are on the wire.
    function automatic logic is_busy(input tx_state_e s);
        return (s == ST_SEND) || (s == ST_TAIL);
    endfunction

endpackage

// File: rtl/des_buf2.sv
// -----------------------------------------------------------------------------
// des_buf2
// Two-entry FIFO holding {stream select, descriptor} words.
//   iclk    : clock, rising edge
//   irst    : asynchronous active-low reset
//   i_push  : write i_data (ignored when full)
//   i_pop   : drop the head entry (ignored when empty)
//   i_data  : word to store
//   o_head  : oldest stored word
//   o_count : number of stored words (0..2)
// -----------------------------------------------------------------------------
module des_buf2 #(
    parameter int W = 8
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign push_ok_s = i_push && (count_q != 2'd2);
    assign pop_ok_s  = i_pop && (count_q != 2'd0);

    // Next pointer and occupancy values.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok_s) begin
            wr_d = ~wr_q;
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = ~rd_q;
        end else begin
            rd_d = rd_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= i_data;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[rd_q];
    assign o_count = count_q;

endmodule

// File: rtl/des_stream_tx.sv
// -----------------------------------------------------------------------------
// des_stream_tx
// Buffers up to two descriptors and streams each one out as N_CHUNKS chunks of
// CHUNK_W bits, LSB chunk first, followed by a tail and one gap cycle.
//   iclk          : clock, rising edge
//   irst          : asynchronous active-low reset
//   i_load        : enqueue request for {i_sw, i_des}
//   i_des         : descriptor
//   i_sw          : stream select (0 base image, 1 scene)
//   i_hold        : downstream stall, freezes an active stream
//   o_Des         : current chunk
//   o_des_sw      : stream select of the descriptor being sent
//   o_des_seq_idx : chunk index 1..N_CHUNKS, 0 when not streaming
//   o_ready       : buffer can accept i_load this cycle
//   o_busy        : streaming a descriptor (SEND or TAIL)
//   o_done        : pulse in the last tail cycle
//   o_ovf         : pulse when an i_load was dropped
// -----------------------------------------------------------------------------
module des_stream_tx
    import sift_match_pkg::*;
#(
    parameter int CHUNK_W  = sift_match_pkg::CHUNK_W,
    parameter int N_CHUNKS = sift_match_pkg::N_CHUNKS,
    parameter int TAIL_CYC = 1
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          i_load,
    input  logic [CHUNK_W*N_CHUNKS-1:0]   i_des,
    input  logic                          i_sw,
    input  logic                          i_hold,
    output logic [CHUNK_W-1:0]            o_Des,
    output logic                          o_des_sw,
    output logic [IDX_W-1:0]              o_des_seq_idx,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_ovf
);

    localparam int DES_W = CHUNK_W * N_CHUNKS;

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic               sw_q, sw_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic [7:0]         tail_q, tail_d;
    logic               pend_q, pend_d;
    logic [DES_W-1:0]   work_q, work_d;

    logic               push_s;
    logic               pop_s;
    logic               ready_s;
    logic [1:0]         count_s;
    logic [DES_W:0]     head_s;

    des_buf2 #(
        .W (DES_W + 1)
    ) u_buf (
        .iclk    (iclk),
        .irst    (irst),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_data  ({i_sw, i_des}),
        .o_head  (head_s),
        .o_count (count_s)
    );

    assign ready_s = (count_s < 2'd2);
    assign push_s  = i_load && ready_s;
    assign ovf_d   = i_load && !ready_s;

    // Next state and next registered outputs of the streaming FSM.
    // A descriptor arriving into an idle block waits one cycle (pend_q) before
    // it is popped; from GAP a queued descriptor is popped straight away so
    // back-to-back streams are separated by exactly one zero-index cycle.
    // The cycle that pops also emits chunk 1 directly from the buffer head.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chunk_d = chunk_q;
        sw_d    = sw_q;
        done_d  = 1'b0;
        tail_d  = tail_q;
        pend_d  = 1'b0;
        work_d  = work_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                chunk_d = '0;
                if (pend_q && (count_s != 2'd0)) begin
                    pop_s   = 1'b1;
                    work_d  = head_s[DES_W-1:0];
                    sw_d    = head_s[DES_W];
                    idx_d   = IDX_W'(1);
                    chunk_d = head_s[CHUNK_W-1:0];
                    state_d = ST_SEND;
                end else begin
                    pend_d = (count_s != 2'd0);
                end
            end
            ST_SEND: begin
                if (i_hold) begin
                    done_d = done_q;
                end else if (idx_q == IDX_W'(N_CHUNKS)) begin
                    state_d = ST_TAIL;
                    tail_d  = 8'd1;
                    done_d  = (8'(TAIL_CYC) == 8'd1);
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    // idx_q is the 1-based index on the wire, i.e. the
                    // 0-based index of the chunk that follows it.
                    chunk_d = work_q[CHUNK_W*int'(idx_q) +: CHUNK_W];
                end
            end
            ST_TAIL: begin
                if (i_hold) begin
                    done_d = done_q;
                end else if (tail_q >= 8'(TAIL_CYC)) begin
                    state_d = ST_GAP;
                    idx_d   = '0;
                    chunk_d = '0;
                end else begin
                    tail_d = tail_q + 8'd1;
                    done_d = ((tail_q + 8'd1) == 8'(TAIL_CYC));
                end
            end
            ST_GAP: begin
                if (count_s != 2'd0) begin
                    pop_s   = 1'b1;
                    work_d  = head_s[DES_W-1:0];
                    sw_d    = head_s[DES_W];
                    idx_d   = IDX_W'(1);
                    chunk_d = head_s[CHUNK_W-1:0];
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                chunk_d = '0;
            end
        endcase
        busy_d = is_busy(state_d);
    end

    // FSM state, working descriptor and registered outputs.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            chunk_q <= '0;
            sw_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            tail_q  <= 8'd0;
            pend_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chunk_q <= chunk_d;
            sw_q    <= sw_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            tail_q  <= tail_d;
            pend_q  <= pend_d;
            work_q  <= work_d;
        end
    end

    assign o_Des         = chunk_q;
    assign o_des_sw      = sw_q;
    assign o_des_seq_idx = idx_q;
    assign o_ready       = ready_s;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_ovf         = ovf_q;

endmodule
